// File: rtl/fifo_rd_streamer_pkg.sv
// Shared definitions for the FIFO read-side streamer and its skid buffer.
package fifo_rd_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam int unsigned SKID_DEPTH = 2;

  // Defaults shared with the asynchronous FIFO.
  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_BURST_LEN = 4;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry register skid buffer; entry 0 is the head and drives the output.
module fifo_skid2
  import fifo_rd_streamer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] ent0_q;
  logic [WIDTH-1:0] ent1_q;
  logic [1:0]       cnt_q;

  // Entry storage and occupancy; flush empties the buffer outright.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_q <= data_i;
          else               ent1_q <= data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Pop and push together: occupancy stays, order is preserved.
          if (cnt_q == 2'd1) begin
            ent0_q <= data_i;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o  = ent0_q;
  assign valid_o = (cnt_q != 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/fifo_rd_streamer.sv
// FIFO read-port to valid/ready stream converter with burst framing,
// flush and sticky underflow error reporting.
module fifo_rd_streamer
  import fifo_rd_streamer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int BURST_LEN  = DEFAULT_BURST_LEN,
  parameter int BCNT_WIDTH = 2,
  parameter int WCNT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [WIDTH-1:0]      fifo_rdata_i,
  input  logic                  fifo_rd_error_i,
  output logic [WIDTH-1:0]      m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  err_o,
  input  logic                  err_clr_i,
  output logic [WCNT_WIDTH-1:0] word_cnt_o
);

  localparam logic [BCNT_WIDTH-1:0] LAST_BEAT = BCNT_WIDTH'(BURST_LEN - 1);

  state_t                  state_q, state_d;
  logic                    rd_en_q;   // doubles as the in-flight flag
  logic [1:0]              skid_count;
  logic                    skid_valid;
  logic [WIDTH-1:0]        skid_head;
  logic [BCNT_WIDTH-1:0]   beat_q;
  logic [WCNT_WIDTH-1:0]   wcnt_q;
  logic                    err_q;
  logic                    issue, handshake, ret_err, push, pop;

  assign handshake = skid_valid & m_ready_i;
  assign issue     = (state_q != FLUSH) && !flush_i && !fifo_empty_i &&
                     (({1'b0, skid_count} + {2'b00, rd_en_q}) < 3'(SKID_DEPTH));
  assign ret_err   = rd_en_q & fifo_rd_error_i;
  assign push      = rd_en_q & ~fifo_rd_error_i & ~flush_i & (state_q != FLUSH);
  assign pop       = handshake & ~flush_i;

  fifo_skid2 #(.WIDTH(WIDTH)) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (fifo_rdata_i),
    .pop_i   (pop),
    .flush_i (flush_i),
    .head_o  (skid_head),
    .valid_o (skid_valid),
    .count_o (skid_count)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides every state.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE:    if (issue) state_d = STREAM;
        STREAM:  if (skid_count == 2'd0 && !rd_en_q && fifo_empty_i) state_d = IDLE;
        FLUSH:   if (!rd_en_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered read enable; the read is in flight for exactly one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_en_q <= 1'b0;
    else       rd_en_q <= issue;
  end

  // Beat counter for burst framing and delivered-word counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_q <= '0;
      wcnt_q <= '0;
    end else begin
      if (handshake) wcnt_q <= wcnt_q + WCNT_WIDTH'(1);
      if (flush_i)                beat_q <= '0;
      else if (handshake) begin
        if (beat_q == LAST_BEAT)  beat_q <= '0;
        else                      beat_q <= beat_q + BCNT_WIDTH'(1);
      end
    end
  end

  // Sticky underflow flag; a new error wins over a clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          err_q <= 1'b0;
    else if (ret_err)   err_q <= 1'b1;
    else if (err_clr_i) err_q <= 1'b0;
  end

  assign fifo_rd_en_o = rd_en_q;
  assign m_data_o     = skid_head;
  assign m_valid_o    = skid_valid;
  assign m_last_o     = skid_valid && (beat_q == LAST_BEAT);
  assign busy_o       = (state_q != IDLE);
  assign err_o        = err_q;
  assign word_cnt_o   = wcnt_q;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Scoreboard bench for fifo_rd_streamer with a small behavioural FIFO model.
module tb_fifo_rd_streamer;

  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rdata;
  logic        fifo_rd_error;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        flush = 1'b0;
  logic        busy;
  logic        err;
  logic        err_clr = 1'b0;
  logic [15:0] word_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  sb[$];
  int          exp_beat = 0;

  // FIFO model: show-ahead data, empty looks ahead past the pending read.
  logic [7:0]  mem [0:63];
  int unsigned wptr = 0;
  int unsigned rptr = 0;
  int unsigned rd_count = 0;
  logic        err_arm = 1'b0;

  assign fifo_rdata    = mem[rptr[5:0]];
  assign fifo_empty    = (wptr == rptr) || ((wptr - rptr) == 1 && fifo_rd_en);
  assign fifo_rd_error = fifo_rd_en && ((wptr == rptr) || err_arm);

  always @(posedge clk or posedge rst) begin
    if (rst)                             rptr <= wptr;
    else if (fifo_rd_en && wptr != rptr) rptr <= rptr + 1;
  end

  always @(posedge clk) if (fifo_rd_en) rd_count = rd_count + 1;

  always #5 clk = ~clk;

  fifo_rd_streamer #(
    .WIDTH      (8),
    .BURST_LEN  (BURST),
    .BCNT_WIDTH (2),
    .WCNT_WIDTH (16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .fifo_empty_i    (fifo_empty),
    .fifo_rd_en_o    (fifo_rd_en),
    .fifo_rdata_i    (fifo_rdata),
    .fifo_rd_error_i (fifo_rd_error),
    .m_data_o        (m_data),
    .m_valid_o       (m_valid),
    .m_ready_i       (m_ready),
    .m_last_o        (m_last),
    .flush_i         (flush),
    .busy_o          (busy),
    .err_o           (err),
    .err_clr_i       (err_clr),
    .word_cnt_o      (word_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every handshake pops the scoreboard.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_beat", {24'd0, m_data}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        check_eq("data", m_data, e);
        check_eq("last", m_last, (exp_beat == BURST - 1));
        exp_beat = (exp_beat == BURST - 1) ? 0 : exp_beat + 1;
      end
    end
  end

  task automatic preload(input logic [7:0] first, input int n, input int skip_idx);
    for (int i = 0; i < n; i++) begin
      mem[wptr[5:0]] = first + 8'(i);
      wptr = wptr + 1;
      if (i != skip_idx) sb.push_back(first + 8'(i));
    end
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = !busy && (sb.size() == 0);
    end
    check_eq({tag, "_drain"}, done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rd_base;
    bit seen;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check_eq("rst_valid", m_valid, 0);
    check_eq("rst_rd_en", fifo_rd_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wcnt", word_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Full-rate stream of 8 words
    m_ready = 1'b1;
    preload(8'h11, 8, -1);
    wait_drain("stream8");
    check_eq("stream8_wcnt", word_cnt, 8);
    check_eq("stream8_busy", busy, 0);
    check_eq("stream8_err", err, 0);

    // Stalled sink: exactly two reads, head held stable
    @(posedge clk); #1;
    m_ready = 1'b0;
    rd_base = rd_count;
    preload(8'h11, 8, -1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        check_eq("stall_valid", m_valid, 1);
        check_eq("stall_data", m_data, 8'h11);
      end
    end
    check_eq("stall_reads", rd_count - rd_base, 2);
    check_eq("stall_rderr", err, 0);
    @(posedge clk); #1 m_ready = 1'b1;
    wait_drain("stall");
    check_eq("stall_wcnt", word_cnt, 16);

    // Toggling ready with 6 words
    @(posedge clk); #1;
    preload(8'h31, 6, -1);
    begin
      bit done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
        @(posedge clk); #1 m_ready = ~m_ready;
        @(negedge clk);
        done = !busy && (sb.size() == 0);
      end
      check_eq("toggle_drain", done, 1);
    end
    check_eq("toggle_wcnt", word_cnt, 22);

    // Read error on the first return: word dropped, sticky flag
    @(posedge clk); #1;
    m_ready = 1'b1;
    err_arm = 1'b1;
    preload(8'h41, 3, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = fifo_rd_en;
    end
    check_eq("err_read_seen", seen, 1);
    @(posedge clk); #1 err_arm = 1'b0;
    wait_drain("err");
    check_eq("err_set", err, 1);
    repeat (3) @(negedge clk);
    check_eq("err_sticky", err, 1);
    check_eq("err_wcnt", word_cnt, 24);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check_eq("err_clr", err, 0);

    // Flush with one buffered word and one read in flight
    m_ready = 1'b0;
    @(posedge clk); #1;
    preload(8'h51, 6, -1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = m_valid;
    end
    check_eq("flush_pre_valid", seen, 1);
    check_eq("flush_pre_inflight", fifo_rd_en, 1);
    flush = 1'b1;
    sb.delete();
    exp_beat = 0;
    for (int i = 0; i < 4; i++) sb.push_back(8'h53 + 8'(i));
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check_eq("flush_valid", m_valid, 0);
    check_eq("flush_busy", busy, 1);
    check_eq("flush_last", m_last, 0);
    m_ready = 1'b1;
    wait_drain("flush");
    check_eq("flush_wcnt", word_cnt, 28);
    check_eq("flush_err", err, 0);

    // Asynchronous reset mid-burst
    @(posedge clk); #1;
    preload(8'h61, 8, -1);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_valid", m_valid, 0);
    check_eq("arst_data", m_data, 0);
    check_eq("arst_last", m_last, 0);
    check_eq("arst_rd_en", fifo_rd_en, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_wcnt", word_cnt, 0);
    sb.delete();
    exp_beat = 0;
    @(posedge clk); #1 rst = 1'b0;

    // Normal operation after reset
    preload(8'h71, 4, -1);
    wait_drain("post_rst");
    check_eq("post_rst_wcnt", word_cnt, 4);
    check_eq("post_rst_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
